led_blink_ctrl: RTL

Parametrised multi-channel LED driver for the DE1 board designs. It generalises the single free-running blink counter into CH independent channels. Each channel is software-selectable between OFF, ON, BLINK (programmable period) and PWM (programmable brightness). All channels share one prescaler tick and one PWM phase counter, and the block sits between board-level control logic (switches, keys, or a bus) and the LEDG/LEDR pins.

---
 rtl/led_blink_ctrl_if.sv | 14 +
 rtl/led_blink_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/led_blink_ctrl_if.sv
// Configuration write port of the LED driver: one write strobe plus target channel,
// mode and value. The controller drives it; the LED block receives it.
interface led_blink_ctrl_if #(
  parameter int CW = 3,
  parameter int DW = 8
);
  logic          CFG_WR;
  logic [CW-1:0] CFG_CH;
  logic [1:0]    CFG_MODE;
  logic [DW-1:0] CFG_VAL;

  modport master (output CFG_WR, CFG_CH, CFG_MODE, CFG_VAL);
  modport slave  (input  CFG_WR, CFG_CH, CFG_MODE, CFG_VAL);
endinterface

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: each channel is OFF, ON, BLINK or PWM. All channels share
// one prescaler tick (for blinking) and one free-running PWM phase counter.
module led_blink_ctrl #(
  parameter int CH = 8,
  parameter int PW = 24,
  parameter int DW = 8,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic [PW-1:0]          PRESC,
  led_blink_ctrl_if.slave        cfg,
  output logic [CH-1:0]          LED,
  output logic                   TICK
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  localparam logic [CW:0] CH_L = CH[CW:0];

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick_q, tick_d;
  logic [DW-1:0] ph_q, ph_d;

  mode_e         mode_q [CH];
  mode_e         mode_d [CH];
  logic [DW-1:0] val_q  [CH];
  logic [DW-1:0] val_d  [CH];
  logic [DW-1:0] bcnt_q [CH];
  logic [DW-1:0] bcnt_d [CH];
  logic [CH-1:0] bst_q, bst_d;
  logic [CH-1:0] led_q, led_d;

  logic [CW-1:0] wr_ch;
  logic          wr_hit;

  assign wr_ch  = cfg.CFG_CH;
  assign wr_hit = cfg.CFG_WR && ({1'b0, wr_ch} < CH_L);

  // Shared timebase: >= lets a lowered PRESC force an immediate wrap.
  always_comb begin
    tick_d = (pcnt_q >= PRESC);
    pcnt_d = tick_d ? '0 : pcnt_q + PW'(1);
    ph_d   = ph_q + DW'(1);
  end

  always_comb begin
    mode_d = mode_q;
    val_d  = val_q;
    bcnt_d = bcnt_q;
    bst_d  = bst_q;
    led_d  = '0;
    for (int c = 0; c < CH; c++) begin
      unique case (mode_q[c])
        MODE_OFF:   led_d[c] = 1'b0;
        MODE_ON:    led_d[c] = 1'b1;
        MODE_BLINK: led_d[c] = bst_q[c];
        MODE_PWM:   led_d[c] = (ph_q < val_q[c]);
      endcase

      if (tick_q && (mode_q[c] == MODE_BLINK)) begin
        if (bcnt_q[c] == val_q[c]) begin
          bcnt_d[c] = '0;
          bst_d[c]  = ~bst_q[c];
        end else begin
          bcnt_d[c] = bcnt_q[c] + DW'(1);
        end
      end

      // A write wins over a coincident tick: that tick is simply not counted.
      if (wr_hit && (wr_ch == CW'(c))) begin
        mode_d[c] = mode_e'(cfg.CFG_MODE);
        val_d[c]  = cfg.CFG_VAL;
        bcnt_d[c] = '0;
        bst_d[c]  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      ph_q   <= '0;
      mode_q <= '{default: MODE_OFF};
      val_q  <= '{default: '0};
      bcnt_q <= '{default: '0};
      bst_q  <= '0;
      led_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
      ph_q   <= ph_d;
      mode_q <= mode_d;
      val_q  <= val_d;
      bcnt_q <= bcnt_d;
      bst_q  <= bst_d;
      led_q  <= led_d;
    end
  end

  assign LED  = led_q;
  assign TICK = tick_q;

endmodule
